// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with registered status flags.
//
// Words are written on wr_en and read on rd_en. Read data is registered: dout and dout_valid
// change on the edge after rd_en is sampled. full, empty, almost_full and almost_empty are
// registered from the next count, so they always agree with count. overflow and underflow
// are sticky until err_clr or rst. flush empties the FIFO without touching the storage,
// dout or the error flags.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   flush        synchronous clear of pointers and count
//   wr_en, din   write request and data
//   rd_en        read request
//   dout         registered read data
//   dout_valid   dout was loaded by a read accepted on the previous edge
//   full, empty, almost_full, almost_empty   registered status flags
//   count        occupancy, 0..DEPTH
//   overflow     sticky: a write was rejected
//   underflow    sticky: a read was rejected
//   err_clr      clears overflow and underflow
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 9,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 2,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam logic [AW:0] DepthC   = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AfullC   = (AW + 1)'(AFULL_TH);
    localparam logic [AW:0] AemptyC  = (AW + 1)'(AEMPTY_TH);
    localparam logic [AW:0] CountOne = (AW + 1)'(1);
    localparam logic [AW-1:0] PtrOne = AW'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              rd_ok;
    logic              wr_ok;

    // A write into a full FIFO is allowed only when a read frees a slot on the same edge.
    // A read from an empty FIFO is always rejected, so there is no fall-through.
    assign rd_ok = rd_en & ~empty_q;
    assign wr_ok = wr_en & (~full_q | rd_ok);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;

        if (flush) begin
            // Requests are ignored during flush and raise no error flags.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (rd_ok) begin
                rd_ptr_d     = rd_ptr_q + PtrOne;
                dout_d       = mem_q[rd_ptr_q];
                dout_valid_d = 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + CountOne;
                2'b01:   count_d = count_q - CountOne;
                default: count_d = count_q;
            endcase
            if (wr_en && !wr_ok) begin
                overflow_d = 1'b1;
            end
            if (rd_en && !rd_ok) begin
                underflow_d = 1'b1;
            end
        end

        // Clearing wins over a set event on the same edge.
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        full_d   = (count_d == DepthC);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AfullC);
        aempty_d = (count_d <= AemptyC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            afull_q      <= 1'b0;
            aempty_q     <= 1'b1;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            afull_q      <= afull_d;
            aempty_q     <= aempty_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DATA_W=9, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2).
// A queue-based model predicts every output after each clock edge.
module tb_sync_fifo_param;

    localparam int DATA_W    = 9;
    localparam int DEPTH     = 8;
    localparam int AFULL_TH  = DEPTH - 2;
    localparam int AEMPTY_TH = 2;
    localparam int AW        = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [AW:0]       count;
    logic              overflow;
    logic              underflow;
    logic              err_clr;

    sync_fifo_param #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [DATA_W-1:0] mq [$];
    logic [DATA_W-1:0] m_dout = '0;
    logic              m_dv   = 1'b0;
    logic              m_ovf  = 1'b0;
    logic              m_unf  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit w, input bit r, input logic [DATA_W-1:0] d,
                              input bit f, input bit ec, input bit rs);
        bit r_ok;
        bit w_ok;
        if (rs) begin
            mq.delete();
            m_dout = '0;
            m_dv   = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else if (f) begin
            mq.delete();
            m_dv = 1'b0;
            if (ec) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
        end else begin
            r_ok = r && (mq.size() > 0);
            w_ok = w && ((mq.size() < DEPTH) || r_ok);
            if (r_ok) m_dout = mq.pop_front();
            m_dv = r_ok;
            if (w_ok) mq.push_back(d);
            if (ec) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                if (w && !w_ok) m_ovf = 1'b1;
                if (r && !r_ok) m_unf = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        int n;
        n = mq.size();
        check_val("count", 32'(count), n);
        check_val("empty", 32'(empty), 32'(n == 0));
        check_val("full", 32'(full), 32'(n == DEPTH));
        check_val("almost_full", 32'(almost_full), 32'(n >= AFULL_TH));
        check_val("almost_empty", 32'(almost_empty), 32'(n <= AEMPTY_TH));
        check_val("dout_valid", 32'(dout_valid), 32'(m_dv));
        check_val("dout", 32'(dout), 32'(m_dout));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
        check_val("underflow", 32'(underflow), 32'(m_unf));
    endtask

    // Drive one cycle of inputs, step the model, sample 1 ns after the edge.
    task automatic cyc(input bit w, input bit r, input logic [DATA_W-1:0] d,
                       input bit f, input bit ec, input bit rs);
        wr_en   = w;
        rd_en   = r;
        din     = d;
        flush   = f;
        err_clr = ec;
        rst     = rs;
        model_step(w, r, d, f, ec, rs);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [DATA_W-1:0] d);
        cyc(1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        cyc(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clr();
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0; err_clr = 1'b0;
        @(negedge clk);

        // Reset, then idle
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_val("reset_dout", 32'(dout), 0);
        check_val("reset_empty", 32'(empty), 1);
        idle();

        // Fill 0x101..0x108
        for (int i = 0; i < 8; i++) begin
            wr(9'(9'h101 + i));
            if (i == 4) check_val("fill5_afull", 32'(almost_full), 0);
            if (i == 5) check_val("fill6_afull", 32'(almost_full), 1);
        end
        check_val("fill_full", 32'(full), 1);
        check_val("fill_count", 32'(count), 8);

        // Overflowing write
        wr(9'h1FF);
        check_val("ovf_flag", 32'(overflow), 1);
        check_val("ovf_count", 32'(count), 8);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            rd();
            check_val("drain_dout", 32'(dout), 32'(9'h101 + i));
            check_val("drain_valid", 32'(dout_valid), 1);
        end
        check_val("drain_empty", 32'(empty), 1);
        rd();
        check_val("unf_flag", 32'(underflow), 1);
        check_val("unf_dout_hold", 32'(dout), 32'(9'h108));
        clr();

        // Wrap-around
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5; i++) wr(9'($urandom));
            for (int i = 0; i < 5; i++) rd();
        end
        check_val("wrap_count", 32'(count), 0);

        // Simultaneous at full
        for (int i = 0; i < 8; i++) wr(9'($urandom));
        cyc(1'b1, 1'b1, 9'h0AA, 1'b0, 1'b0, 1'b0);
        check_val("full_rw_count", 32'(count), 8);
        check_val("full_rw_full", 32'(full), 1);
        check_val("full_rw_ovf", 32'(overflow), 0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Simultaneous at empty
        cyc(1'b1, 1'b1, 9'h055, 1'b0, 1'b0, 1'b0);
        check_val("empty_rw_count", 32'(count), 1);
        check_val("empty_rw_unf", 32'(underflow), 1);
        rd();
        check_val("empty_rw_dout", 32'(dout), 32'(9'h055));
        clr();

        // Flush with 4 entries and overflow set, write requested in the same cycle
        for (int i = 0; i < 9; i++) wr(9'(9'h010 + i));
        for (int i = 0; i < 4; i++) rd();
        check_val("pre_flush_count", 32'(count), 4);
        cyc(1'b1, 1'b0, 9'h1EE, 1'b1, 1'b0, 1'b0);
        check_val("flush_count", 32'(count), 0);
        check_val("flush_empty", 32'(empty), 1);
        check_val("flush_ovf", 32'(overflow), 1);
        idle();
        clr();
        check_val("errclr_ovf", 32'(overflow), 0);

        // Reset mid-operation with a read pending
        for (int i = 0; i < 5; i++) wr(9'($urandom));
        cyc(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
        check_val("rst_count", 32'(count), 0);
        check_val("rst_dout", 32'(dout), 0);
        check_val("rst_valid", 32'(dout_valid), 0);

        // Randomized traffic, alternating write-heavy and read-heavy phases
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 400; i++) begin
                bit w, r, f, ec, rs;
                w  = ($urandom_range(99) < ((ph % 2 == 0) ? 75 : 35));
                r  = ($urandom_range(99) < ((ph % 2 == 0) ? 35 : 75));
                f  = ($urandom_range(99) < 2);
                ec = ($urandom_range(99) < 5);
                rs = ($urandom_range(199) < 1);
                cyc(w, r, 9'($urandom), f, ec, rs);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO that succeeds the fixed 8x9 FIFO. Data width and depth are generic, and pointers are managed internally from plain write/read requests instead of externally driven increment/clear strobes. It adds registered full/empty/almost flags, an occupancy count, sticky overflow/underflow error flags and a flush control. It sits between a producer and a consumer in the same clock domain.

## Interface
- DATA_W, 9, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AFULL_TH, DEPTH-2, almost_full asserts when count ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, almost_empty asserts when count ≤ AEMPTY_TH (0..DEPTH-1)

Ports, with AW = log2(DEPTH):
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous pointer/count clear; storage untouched
- wr_en  in  1  write request
- din  in  DATA_W  write data
- rd_en  in  1  read request
- dout  out  DATA_W  registered read data
- dout_valid  out  1  dout holds a word read in the previous cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_TH
- almost_empty  out  1  count ≤ AEMPTY_TH
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected
- err_clr  in  1  clears overflow/underflow

## Operation
- Storage is a DEPTH x DATA_W register array. wr_ptr and rd_ptr are AW bits wide and wrap naturally from DEPTH-1 to 0.
- Read accepted (rd_ok) = rd_en & !empty.
- Write accepted (wr_ok) = wr_en & (!full | rd_ok). A write to a full FIFO succeeds only when a read is accepted in the same cycle.
- On a write to an empty FIFO with a simultaneous read, the read is rejected and the write is accepted. There is no fall-through.
- wr_ok: mem[wr_ptr] ← din, then wr_ptr+1.
- rd_ok: dout ← mem[rd_ptr], then rd_ptr+1, and dout_valid ← 1.
- No rd_ok: dout_valid ← 0, and dout holds its last value.
- count next value:
  - count+1 on wr_ok only
  - count−1 on rd_ok only
  - unchanged on both or neither
- full, empty, almost_full and almost_empty are registered and computed from the next count. They are always consistent with count in the same cycle.
- wr_en & !wr_ok sets overflow. rd_en & !rd_ok sets underflow. Both flags stay set until err_clr or rst.
- err_clr has priority over a set event in the same cycle: the flag clears.
- flush:
  - Clears wr_ptr, rd_ptr, count and dout_valid. Flags become empty=1, full=0, almost_empty=1, almost_full=0.
  - wr_en and rd_en are ignored that cycle; no error flags are set.
  - overflow, underflow and dout are unchanged.
- Priority: rst > flush > normal operation. err_clr is independent of flush.

## Timing
- Reset values (one clock edge with rst=1):
  - wr_ptr=0, rd_ptr=0, count=0
  - empty=1, almost_empty=1, full=0, almost_full=0
  - dout=0, dout_valid=0, overflow=0, underflow=0
  - Memory contents are not reset.
- rst asserted mid-operation discards all contents at that edge. wr_en and rd_en are ignored while rst=1.
- Write-to-read latency: a word written at edge N is readable with rd_en sampled at edge N+1; empty deasserts after edge N.
- Read latency: rd_en sampled at edge N gives dout/dout_valid valid after edge N, i.e. during cycle N+1.
- Flags and count update at the same edge as the accepted operation; no extra cycle of lag.
- Sustained throughput is one write and one read per cycle, including at full and at empty+1.
- Ordering is strict FIFO across pointer wrap-around.

## Test plan
- Reset then idle: empty=1, almost_empty=1, count=0, dout=0, dout_valid=0, full=0, overflow=0.
- DEPTH=8, DATA_W=9, fill and drain:
  - Write 0x101..0x108 → after the 6th write almost_full=1; after the 8th, full=1 and count=8.
  - 9th write (0x1FF) → overflow=1, count stays 8.
  - Read 8 → dout sequence 0x101..0x108, each with dout_valid=1; ends with empty=1.
  - 9th read → underflow=1.
- Wrap-around: write 5 / read 5, three times (15 words across the pointer wrap) → data order preserved, count returns to 0.
- Simultaneous operations:
  - At full, wr_en+rd_en → both accepted; count stays 8, full stays 1, no overflow.
  - At empty, wr_en+rd_en → write accepted, read rejected; count=1, underflow=1.
- Flush with 4 entries and overflow=1, with wr_en=1 in the same cycle → count=0, empty=1, overflow stays 1, no write performed. Following err_clr → overflow=0.
- rst asserted with count=5 while a read is pending → next cycle count=0, dout=0, dout_valid=0, all flags at reset values.
